mult_div_unit: RTL
==================

# mult_div_unit

Multicycle integer multiply/divide unit with architectural HI/LO registers, directly downstream of the register file. It consumes the two register read ports (`read_data_1`, `read_data_2`) as operands for MULT/MULTU/DIV/DIVU and holds the results until MFHI/MFLO read them. Operations are iterative, one bit per cycle, with a `busy` flag the control path uses to stall.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request an operation; sampled only when idle.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `operand_a`  in  WIDTH  rs value / dividend, from `read_data_1`.
- `operand_b`  in  WIDTH  rt value / divisor, from `read_data_2`.
- `hi_we`  in  1  MTHI: write `write_data` to HI.
- `lo_we`  in  1  MTLO: write `write_data` to LO.
- `write_data`  in  WIDTH  MTHI/MTLO source.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX. Reset puts the unit in IDLE. `busy`, `done`, `hi` and `lo` all reset to 0. The iteration counter resets to 0.
- IDLE with `start`=1: the unit latches |a| and |b|, or the raw values for unsigned ops. It latches the result signs, loads counter = 31, then moves to CALC.
- CALC: one iteration per cycle; when counter = 0, moves to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX: applies two's-complement sign correction, writes HI/LO, pulses `done`, then returns to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0]. Product is negated if sign(a)^sign(b) for MULT.
  - Divide: LO = quotient, HI = remainder. For DIV, the quotient sign is sign(a)^sign(b) and the remainder sign is sign(a).
- Divide by zero runs the normal latency. Result: LO = 32'hFFFF_FFFF, HI = operand_a as latched, sign-restored for DIV.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF wraps: LO = 32'h8000_0000, HI = 0.
- `start` while `busy` is ignored; operands are not re-latched.
- `hi_we`/`lo_we` act only in IDLE and are ignored while `busy`.
  - `start` together with `hi_we`/`lo_we` in IDLE: MTHI/MTLO is applied and the operation also starts; the later result overwrites HI/LO.
- Reset mid-operation aborts immediately: IDLE, HI = LO = 0, no `done`.

## Timing
- Posedge 0 samples `start`. `busy` is high from posedge 0 through posedge 33 and low after posedge 33.
- HI/LO update and `done` = 1 both occur at posedge 33, and `done` drops at posedge 34. Total latency is 33 cycles, identical for all ops and operands.
- A new `start` can be accepted at posedge 34, giving back-to-back throughput of one op per 34 cycles.
- MTHI/MTLO in IDLE take effect at the next posedge; `hi`/`lo` are register outputs with no combinational path from the inputs.

## Configuration
- `MIPS_DIV_EN` defined: DIVU/DIV are implemented as above.
- `MIPS_DIV_EN` undefined: the divide datapath is removed. `start` with `op[1]`=1 is ignored: the unit stays IDLE, `busy` stays low, no `done`, and HI/LO are unchanged. Multiply behaviour and latency are unchanged.

## Structure
- Shared package `mips_pkg` holds:
  - the `md_op_t` encoding (MULTU/MULT/DIVU/DIV);
  - the `md_state_t` enum (IDLE/CALC/FIX);
  - the constant `MD_ITERS` = 32.
- One sub-module, `md_sign_fix`: combinational conditional two's-complement negate of a 2*WIDTH value. It is used for operand abs and result correction.

## Test plan
- Reset, then MULTU a=32'hFFFF_FFFF, b=2 -> `done` at cycle 33; HI=1, LO=32'hFFFF_FFFE.
- MULT a=-3, b=7 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB (-21).
- DIV a=-7, b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU a=100, b=0 -> LO=32'hFFFF_FFFF, HI=100.
- Second `start` plus `hi_we` at cycle 10 of a MULTU 5*6 -> both ignored; HI=0, LO=30 at cycle 33.
- Reset asserted at cycle 20 of a DIVU -> `busy`=0, HI=LO=0 at once, no `done`; a fresh MULTU 3*4 afterwards gives LO=12.
- `MIPS_DIV_EN` undefined: DIVU start -> `busy` stays 0 for 40 cycles and HI/LO are unchanged; MTLO 32'h1234 in IDLE -> `lo`=32'h1234 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states,
// and the per-operation iteration count.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } md_state_t;

    localparam int MD_ITERS = 32;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore result signs.
module md_sign_fix #(
    parameter int W = 64
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    always_comb begin
        result = negate ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO, one bit per cycle.
// Define MIPS_DIV_EN to build the divide datapath; otherwise divide requests are ignored.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MD_ITERS);

    md_state_t          state, state_nxt;
    md_op_t             op_in;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH:0]     add_sum;
    logic               neg_res;
    logic               signed_op, neg_a, neg_b, op_ok, accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef MIPS_DIV_EN
    logic               is_div, neg_rem;
    logic [WIDTH:0]     partial, diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op[1];
`endif

    assign op_in     = md_op_t'(op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign neg_a     = signed_op & operand_a[WIDTH-1];
    assign neg_b     = signed_op & operand_b[WIDTH-1];
    assign accept    = (state == IDLE) && start && op_ok;
    assign busy      = (state != IDLE);

    md_sign_fix #(.W(WIDTH)) u_abs_a (.value(operand_a), .negate(neg_a), .result(abs_a));
    md_sign_fix #(.W(WIDTH)) u_abs_b (.value(operand_b), .negate(neg_b), .result(abs_b));
    md_sign_fix #(.W(2*WIDTH)) u_prod (.value(acc), .negate(neg_res), .result(prod_fix));

`ifdef MIPS_DIV_EN
    md_sign_fix #(.W(WIDTH)) u_quo (.value(acc[WIDTH-1:0]), .negate(neg_res), .result(quo_fix));
    md_sign_fix #(.W(WIDTH)) u_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(rem_fix));
`endif

    // Multiply keeps the multiplier in acc's low half and shifts right; divide
    // reuses acc as {remainder, dividend/quotient} shifting left.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt = {add_sum, acc[WIDTH-1:1]};
`ifdef MIPS_DIV_EN
        partial = acc[2*WIDTH-1:WIDTH-1];
        diff    = partial - {1'b0, mcand};
        if (is_div) begin
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (count == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            mcand   <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MIPS_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= write_data;
                    if (lo_we) lo <= write_data;
                    if (accept) begin
                        count   <= CW'(MD_ITERS - 1);
                        mcand   <= abs_b;
                        acc     <= {{WIDTH{1'b0}}, abs_a};
                        neg_res <= neg_a ^ neg_b;
`ifdef MIPS_DIV_EN
                        is_div  <= op[1];
                        neg_rem <= neg_a;
                        // Divide by zero yields an all-ones quotient regardless of sign.
                        if (op[1] && (operand_b == '0)) neg_res <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    count <= count - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
`ifdef MIPS_DIV_EN
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
`else
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
